// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: issues 8-byte-aligned reads to instruction memory,
// splits each 64-bit response into one or two 32-bit instructions and buffers
// them with their PCs for the core. A redirect flushes the buffer and restarts
// fetch at the new target; an in-flight request completes and its data is dropped.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr memory read request channel
//   resp_valid/resp_data        memory read response (one per accepted request)
//   inst_valid/inst_ready       instruction handshake to the core
//   inst, inst_pc               head instruction and its PC
//   redirect_valid/redirect_pc  flush and refetch from redirect_pc
//
// Optional build macro IFU_PERF_EN adds saturating counters
//   perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt.
module ysyx_22040127_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic        drop_pend, drop_pend_nxt;
  logic        req_valid_nxt;
  logic [31:0] req_addr_nxt;

  // Shift-register buffer: entry 0 is always the head, so inst/inst_pc/inst_valid
  // come straight from flops.
  logic [31:0]           ent_inst     [FIFO_DEPTH];
  logic [31:0]           ent_pc       [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [31:0]           ent_inst_nxt [FIFO_DEPTH];
  logic [31:0]           ent_pc_nxt   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld_nxt;
  logic [CNT_W-1:0]      cnt, base, free_cnt;
  logic [CNT_W:0]        cnt_wide;

  logic        keep, two, pop;
  logic [1:0]  n_push;
  logic [31:0] w0_inst, w0_pc, w1_inst, w1_pc;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign free_cnt = CNT_W'(FIFO_DEPTH) - cnt;
  assign keep     = (state == S_WAIT) && resp_valid && !redirect_valid;
  assign two      = !fetch_pc[2];
  assign n_push   = keep ? (two ? 2'd2 : 2'd1) : 2'd0;
  assign pop      = ent_vld[0] && inst_ready && !redirect_valid;
  assign w0_inst  = fetch_pc[2] ? resp_data[63:32] : resp_data[31:0];
  assign w0_pc    = fetch_pc;
  assign w1_inst  = resp_data[63:32];
  assign w1_pc    = fetch_pc + 32'd4;

  assign inst_valid = ent_vld[0];
  assign inst       = ent_inst[0];
  assign inst_pc    = ent_pc[0];

  // Buffer next state: shift on pop, then write new words behind the survivors.
  always_comb begin
    ent_inst_nxt = ent_inst;
    ent_pc_nxt   = ent_pc;
    ent_vld_nxt  = ent_vld;
    base         = cnt;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        ent_inst_nxt[i] = ent_inst[i+1];
        ent_pc_nxt[i]   = ent_pc[i+1];
        ent_vld_nxt[i]  = ent_vld[i+1];
      end
      ent_vld_nxt[FIFO_DEPTH-1] = 1'b0;
      base = cnt - CNT_W'(1);
    end
    if (keep) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (CNT_W'(i) == base) begin
          ent_inst_nxt[i] = w0_inst;
          ent_pc_nxt[i]   = w0_pc;
          ent_vld_nxt[i]  = 1'b1;
        end
        if (two && (CNT_W'(i) == base + CNT_W'(1))) begin
          ent_inst_nxt[i] = w1_inst;
          ent_pc_nxt[i]   = w1_pc;
          ent_vld_nxt[i]  = 1'b1;
        end
      end
    end
    cnt_wide = (CNT_W+1)'(base) + (CNT_W+1)'(n_push);
    if (redirect_valid) begin
      ent_vld_nxt = '0;
      cnt_wide    = '0;
    end
  end

  // Fetch FSM and PC update; a redirect always wins over a kept response.
  always_comb begin
    state_nxt     = state;
    drop_pend_nxt = drop_pend;
    req_valid_nxt = req_valid;
    req_addr_nxt  = req_addr;
    fetch_pc_nxt  = fetch_pc;
    case (state)
      S_IDLE: begin
        if (!redirect_valid && (free_cnt >= CNT_W'(2))) begin
          state_nxt     = S_REQ;
          req_valid_nxt = 1'b1;
          req_addr_nxt  = {fetch_pc[31:3], 3'b000};
          drop_pend_nxt = 1'b0;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          req_valid_nxt = 1'b0;
          drop_pend_nxt = 1'b0;
          state_nxt     = (redirect_valid || drop_pend) ? S_DROP : S_WAIT;
        end else if (redirect_valid) begin
          drop_pend_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (resp_valid)          state_nxt = S_IDLE;
        else if (redirect_valid) state_nxt = S_DROP;
      end
      S_DROP: begin
        if (resp_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (redirect_valid)
      fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
    else if (keep)
      fetch_pc_nxt = fetch_pc + (fetch_pc[2] ? 32'd4 : 32'd8);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      drop_pend <= 1'b0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      cnt       <= '0;
      ent_vld   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        ent_inst[i] <= '0;
        ent_pc[i]   <= '0;
      end
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      drop_pend <= drop_pend_nxt;
      req_valid <= req_valid_nxt;
      req_addr  <= req_addr_nxt;
      cnt       <= cnt_wide[CNT_W-1:0];
      ent_vld   <= ent_vld_nxt;
      ent_inst  <= ent_inst_nxt;
      ent_pc    <= ent_pc_nxt;
    end
  end

  // The free-space check at issue must make overflow impossible.
  assert property (@(posedge clk) disable iff (!rst)
                   cnt_wide <= (CNT_W+1)'(FIFO_DEPTH));

`ifdef IFU_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req_valid && req_ready && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (inst_ready && !inst_valid && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// Self-checking bench for ysyx_22040127_ifu: memory model, scoreboard queue of
// expected instructions, a table of redirect vectors and hand-written corner cases.
module tb_ysyx_22040127_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
`endif

  ysyx_22040127_ifu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] model_pc = 32'h8000_0000;
  bit          dirty = 1'b0;
  bit          outstanding = 1'b0;
  bit          mon_en = 1'b0;
  int          acc_cnt = 0;
  int          kept_cnt = 0;
  int          redir_cnt = 0;
  int          stall_cnt = 0;
  logic [31:0] last_acc_addr = 32'h0;
  int          mem_lat = 1;

  function automatic logic [31:0] word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_inst_valid(input string name, input int max);
    int n = 0;
    while (!inst_valid && n < max) begin
      step();
      n++;
    end
    if (!inst_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: inst_valid still 0 after %0d cycles", name, max);
    end
  endtask

  task automatic wait_accept(input string name, input int max);
    int base = acc_cnt;
    int n = 0;
    while (acc_cnt == base && n < max) begin
      step();
      n++;
    end
    if (acc_cnt == base) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no request accepted after %0d cycles", name, max);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check32("inst_valid", 32'(inst_valid), 32'(exp_pc_q.size() != 0));
      if (inst_valid && exp_pc_q.size() != 0) begin
        check32("inst_pc", inst_pc, exp_pc_q[0]);
        check32("inst", inst, exp_inst_q[0]);
        if (inst_ready && !redirect_valid) begin
          void'(exp_pc_q.pop_front());
          void'(exp_inst_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        acc_cnt++;
        last_acc_addr = req_addr;
        if (!dirty) check32("req_addr", req_addr, {model_pc[31:3], 3'b000});
        outstanding = 1'b1;
      end
      if (resp_valid) begin
        if (!dirty && !redirect_valid) begin
          kept_cnt++;
          if (!model_pc[2]) begin
            exp_pc_q.push_back(model_pc);
            exp_inst_q.push_back(word(model_pc));
            exp_pc_q.push_back(model_pc + 32'd4);
            exp_inst_q.push_back(word(model_pc + 32'd4));
            model_pc = model_pc + 32'd8;
          end else begin
            exp_pc_q.push_back(model_pc);
            exp_inst_q.push_back(word(model_pc));
            model_pc = model_pc + 32'd4;
          end
        end
        outstanding = 1'b0;
        dirty = 1'b0;
      end
      if (redirect_valid) begin
        redir_cnt++;
        exp_pc_q.delete();
        exp_inst_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
        if (req_valid || outstanding) dirty = 1'b1;
      end
      if (inst_ready && !inst_valid) stall_cnt++;
    end
  end

  // Memory model: answers each accepted request mem_lat+1 cycles later.
  initial begin
    int seen = 0;
    int pend = 0;
    logic [31:0] paddr = 32'h0;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      step();
      resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          resp_valid = 1'b1;
          resp_data  = {word(paddr + 32'd4), word(paddr)};
        end
      end
      if (acc_cnt != seen) begin
        seen  = acc_cnt;
        paddr = last_acc_addr;
        pend  = mem_lat;
      end
    end
  end

  typedef struct {
    logic [31:0] rpc;
    int          lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [31:0] hold_addr;
    int base;
    int n;

    tbl[0] = '{rpc: 32'h8000_0104, lat: 1, exp_addr: 32'h8000_0100, exp_pc: 32'h8000_0104, exp_next: 32'h8000_0108};
    tbl[1] = '{rpc: 32'h8000_0203, lat: 2, exp_addr: 32'h8000_0200, exp_pc: 32'h8000_0200, exp_next: 32'h8000_0208};
    tbl[2] = '{rpc: 32'hFFFF_FFFC, lat: 1, exp_addr: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
    tbl[3] = '{rpc: 32'h0000_0010, lat: 3, exp_addr: 32'h0000_0010, exp_pc: 32'h0000_0010, exp_next: 32'h0000_0018};

    req_ready      = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state.
    repeat (3) step();
    check32("rst_req_valid", 32'(req_valid), 32'h0);
    check32("rst_req_addr", req_addr, 32'h0);
    check32("rst_inst_valid", 32'(inst_valid), 32'h0);
    check32("rst_inst", inst, 32'h0);
    check32("rst_inst_pc", inst_pc, 32'h0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Sequential fetch from the reset PC.
    wait_inst_valid("boot_valid", 40);
    check32("boot_first_pc", inst_pc, 32'h8000_0000);
    check32("boot_first_addr", last_acc_addr, 32'h8000_0000);
    repeat (20) step();

    // Redirect vectors.
    for (int i = 0; i < 4; i++) begin
      mem_lat = tbl[i].lat;
      redirect(tbl[i].rpc);
      check32("tbl_flush", 32'(inst_valid), 32'h0);
      wait_inst_valid("tbl_valid", 60);
      check32("tbl_addr", last_acc_addr, tbl[i].exp_addr);
      check32("tbl_pc", inst_pc, tbl[i].exp_pc);
      wait_accept("tbl_next", 40);
      check32("tbl_next_addr", last_acc_addr, tbl[i].exp_next);
      repeat (8) step();
    end

    // Redirect while waiting for the response to 0x80000010.
    mem_lat = 3;
    redirect(32'h8000_0010);
    n = 0;
    do begin
      wait_accept("wait_acc", 40);
      n++;
    end while (last_acc_addr != 32'h8000_0010 && n < 3);
    check32("wait_acc_addr", last_acc_addr, 32'h8000_0010);
    redirect(32'h8000_0200);
    check32("wait_flush", 32'(inst_valid), 32'h0);
    wait_accept("wait_next", 40);
    check32("wait_next_addr", last_acc_addr, 32'h8000_0200);
    wait_inst_valid("wait_valid", 40);
    check32("wait_pc", inst_pc, 32'h8000_0200);
    repeat (6) step();

    // Back-pressure: buffer fills after two requests, refills only at free >= 2.
    mem_lat = 1;
    inst_ready = 1'b0;
    redirect(32'h8000_0300);
    base = kept_cnt;
    repeat (30) step();
    check32("bp_kept", 32'(kept_cnt - base), 32'd2);
    check32("bp_req_valid", 32'(req_valid), 32'h0);
    check32("bp_inst_valid", 32'(inst_valid), 32'h1);
    check32("bp_head", inst_pc, 32'h8000_0300);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    repeat (10) step();
    check32("bp_one_pop_kept", 32'(kept_cnt - base), 32'd2);
    check32("bp_one_pop_req", 32'(req_valid), 32'h0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    n = 0;
    while (kept_cnt - base < 3 && n < 20) begin
      step();
      n++;
    end
    check32("bp_two_pop_kept", 32'(kept_cnt - base), 32'd3);
    inst_ready = 1'b1;
    repeat (10) step();

    // Request stalled by req_ready=0 with a redirect partway through.
    req_ready = 1'b0;
    redirect(32'h8000_0400);
    n = 0;
    while (!req_valid && n < 20) begin
      step();
      n++;
    end
    hold_addr = req_addr;
    check32("stall_addr", hold_addr, 32'h8000_0400);
    for (int c = 0; c < 5; c++) begin
      redirect_valid = (c == 1);
      redirect_pc    = 32'h8000_0500;
      step();
      check32("stall_req_valid", 32'(req_valid), 32'h1);
      check32("stall_req_addr", req_addr, hold_addr);
    end
    redirect_valid = 1'b0;
    req_ready = 1'b1;
    wait_inst_valid("stall_valid", 40);
    check32("stall_pc", inst_pc, 32'h8000_0500);
    repeat (10) step();

`ifdef IFU_PERF_EN
    check32("perf_fetch", perf_fetch_cnt, 32'(acc_cnt));
    check32("perf_flush", perf_flush_cnt, 32'(redir_cnt));
    check32("perf_stall", perf_stall_cnt, 32'(stall_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040127_ifu.md
Name: ysyx_22040127_ifu

Overview:
Instruction fetch unit directly upstream of the core's decode/execute datapath.
- Issues 8-byte-aligned read requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Extracts 32-bit RV64I instructions, 1 or 2 per 64-bit response, and buffers them with their PCs in a small FIFO.
- Presents them to the core over a valid/ready handshake and flushes on redirect (branch/jump/jalr).

Parameters:
- RESET_PC, 32'h80000000, fetch PC loaded at reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  out  1  memory read request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  32  request address, bits[2:0] always 0.
- resp_valid  in  1  read data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
- resp_data  in  64  read data; [31:0] at addr, [63:32] at addr+4.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  core consumes head.
- inst  out  32  head instruction.
- inst_pc  out  32  head PC.
- redirect_valid  in  1  flush and refetch.
- redirect_pc  in  32  new PC; bits[1:0] ignored (treated as 0).

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, FSM=IDLE, FIFO empty.
  - req_valid=0, req_addr=0, inst_valid=0, inst=0, inst_pc=0.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE->REQ when FIFO free entries >= 2 (counting only the FIFO) and no redirect this cycle.
  - REQ: req_valid=1, req_addr={fetch_pc[31:3],3'b0}. Address held stable until req_ready. On req_valid&req_ready go to WAIT, or to DROP if a redirect occurs in the same cycle or occurred while in REQ.
  - WAIT: on resp_valid, enqueue, advance fetch_pc, go to IDLE. Redirect in WAIT goes to DROP.
  - DROP: on resp_valid, discard data, go to IDLE. fetch_pc already holds the redirect target.
- Enqueue rule on a kept response:
  - fetch_pc[2]=0: push {resp_data[31:0], fetch_pc} then {resp_data[63:32], fetch_pc+4}; fetch_pc += 8.
  - fetch_pc[2]=1: push only {resp_data[63:32], fetch_pc}; fetch_pc += 4.
  - The free>=2 check at issue guarantees space. The FIFO never overflows; an overflow is an assertion failure.
- Dequeue:
  - inst_valid = FIFO not empty.
  - inst/inst_pc come from the registered head entry, so output latency from response is 1 cycle.
  - Pop on inst_valid&inst_ready. Simultaneous push and pop in the same cycle is supported.
- Redirect (any state):
  - FIFO flushed next cycle; inst_valid=0 next cycle.
  - fetch_pc={redirect_pc[31:2],2'b00}.
  - Same-cycle pop is ignored (flush wins).
  - A response arriving in the same cycle as the redirect is discarded.
  - A redirect in REQ does not drop req_valid; the in-flight request completes and is dropped.
  - Back-to-back redirects: the last one wins.
- PC arithmetic is 32-bit and wraps modulo 2^32. Fetch past 32'hFFFFFFF8 wraps to 0 with no error.
- inst_valid is held with stable inst/inst_pc until inst_ready or redirect.

Optional Feature:
IFU_PERF_EN
- Defined:
  - Adds output perf_fetch_cnt[31:0]: count of accepted requests.
  - Adds output perf_flush_cnt[31:0]: count of cycles with redirect_valid=1.
  - Adds output perf_stall_cnt[31:0]: count of cycles with inst_ready=1 and inst_valid=0.
  - All three reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Release reset, memory always ready, 2-cycle response -> first req_addr=32'h80000000; inst_pc sequence 80000000, 80000004, 80000008 with matching words; inst_valid=0 during reset.
- redirect_pc=32'h80000104 while idle -> req_addr=32'h80000100; only the upper word is enqueued with inst_pc=32'h80000104; next req_addr=32'h80000108.
- Redirect to 32'h80000200 during WAIT for addr 80000010 -> 80000010 data never appears on inst; next req_addr=32'h80000200; FIFO empty the cycle after redirect.
- Hold inst_ready=0 with FIFO_DEPTH=4 -> exactly 2 requests issued, then req_valid stays 0 with 4 entries valid; one pop leaves free=1 and still no request; a second pop triggers a new request.
- req_ready held 0 for 5 cycles with a redirect on cycle 2 -> req_valid and req_addr stable throughout; the accepted request's response is dropped, then the redirect target is fetched.
- With IFU_PERF_EN: 10 fetches, 3 redirect cycles -> perf_fetch_cnt=10, perf_flush_cnt=3; preload 32'hFFFFFFFF -> counter stays saturated.
